// File: rtl/keypad_pkg.sv
// ============================================================================
// Module  : keypad_pkg
// Brief   : Shared constants, scan FSM state type and helpers for the keypad scanner.
// Revision: 1.0
// ============================================================================
`default_nettype none

package keypad_pkg;

    localparam int         KEY_W  = 7;
    localparam logic [6:0] NO_KEY = 7'b0;

    localparam logic [3:0] ROW_D = 4'b1000;
    localparam logic [3:0] ROW_C = 4'b0100;
    localparam logic [3:0] ROW_B = 4'b0010;
    localparam logic [3:0] ROW_A = 4'b0001;

    typedef enum logic [1:0] {
        DWELL  = 2'd0,
        SAMPLE = 2'd1,
        EVAL   = 2'd2
    } scan_state_e;

    function automatic logic [1:0] col_count(input logic [2:0] cols);
        return {1'b0, cols[0]} + {1'b0, cols[1]} + {1'b0, cols[2]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_debounce.sv
// ============================================================================
// Module  : keypad_debounce
// Brief   : Multi-scan stability filter and key commit; auto-repeat when
//           KEYPAD_AUTOREPEAT_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             eval,
    input  logic [KEY_W-1:0] scan_code,
    input  logic             scan_amb,
    output logic [KEY_W-1:0] key,
    output logic             key_valid,
    output logic             key_held
);

    localparam int                STAB_W   = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(DEBOUNCE_SCANS);

    if (DEBOUNCE_SCANS < 1) begin : g_bad_debounce
        $error("keypad_debounce: DEBOUNCE_SCANS must be >= 1");
    end
    if (REPEAT_SCANS < 1) begin : g_bad_repeat
        $error("keypad_debounce: REPEAT_SCANS must be >= 1");
    end

    logic [KEY_W-1:0]  cand_q, cand_d;
    logic [STAB_W-1:0] stab_q, stab_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic              held_q, held_d;
    logic              valid_q, valid_d;
    logic              commit;

    // Ambiguous scans are invisible here: candidate, counter and key all hold.
    always_comb begin
        cand_d = cand_q;
        stab_d = stab_q;
        key_d  = key_q;
        held_d = held_q;
        commit = 1'b0;
        if (eval && !scan_amb) begin
            if (scan_code == cand_q) begin
                if (stab_q != STAB_MAX) stab_d = stab_q + 1'b1;
            end else begin
                cand_d = scan_code;
                stab_d = STAB_W'(1);
            end
            if (stab_d == STAB_MAX) begin
                if (cand_d == NO_KEY) begin
                    key_d  = NO_KEY;
                    held_d = 1'b0;
                end else if (cand_d != key_q) begin
                    key_d  = cand_d;
                    held_d = 1'b1;
                    commit = 1'b1;
                end
            end
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int               REP_W    = $clog2(REPEAT_SCANS + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_SCANS - 1);

    logic [REP_W-1:0] rep_q, rep_d;
    logic             rep_pulse;

    // Counts full scans since the last commit or repeat; restarts on any key change.
    always_comb begin
        rep_d     = rep_q;
        rep_pulse = 1'b0;
        if (key_d != key_q || !held_d) begin
            rep_d = '0;
        end else if (eval) begin
            if (rep_q == REP_LAST) begin
                rep_d     = '0;
                rep_pulse = 1'b1;
            end else begin
                rep_d = rep_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rep_q <= '0;
        else     rep_q <= rep_d;
    end

    assign valid_d = commit | rep_pulse;
`else
    assign valid_d = commit;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cand_q  <= NO_KEY;
            stab_q  <= '0;
            key_q   <= NO_KEY;
            held_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            cand_q  <= cand_d;
            stab_q  <= stab_d;
            key_q   <= key_d;
            held_q  <= held_d;
            valid_q <= valid_d;
        end
    end

    assign key       = key_q;
    assign key_held  = held_q;
    assign key_valid = valid_q;

endmodule

`default_nettype wire

// File: rtl/keypad_scanner.sv
// ============================================================================
// Module  : keypad_scanner
// Brief   : 4x3 matrix keypad row scanner with synchronized column sensing and
//           debounced key commit. Optional auto-repeat: KEYPAD_AUTOREPEAT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       col_in,
    output logic [3:0]       row_out,
    output logic [KEY_W-1:0] key,
    output logic             key_valid,
    output logic             key_held
);

    localparam int               CNT_W      = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SCAN_DIV - 1);

    if (SCAN_DIV < 2) begin : g_bad_scan_div
        $error("keypad_scanner: SCAN_DIV must be >= 2");
    end

    scan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       row_q, row_d;
    logic [1:0]       hits_q, hits_d;
    logic [KEY_W-1:0] code_q, code_d;
    logic [2:0]       sync1_q, sync2_q;

    logic [1:0]       pop;
    logic [2:0]       hit_sum;

    assign pop     = col_count(sync2_q);
    assign hit_sum = {1'b0, hits_q} + {1'b0, pop};

    // hits saturates at 2: any second asserted column makes the scan ambiguous.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        hits_d  = hits_q;
        code_d  = code_q;
        unique case (state_q)
            DWELL: begin
                if (cnt_q == '0) state_d = SAMPLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            SAMPLE: begin
                if (hits_q == 2'd0 && pop == 2'd1) code_d = {row_q, sync2_q};
                hits_d = (hit_sum > 3'd2) ? 2'd2 : hit_sum[1:0];
                cnt_d  = CNT_RELOAD;
                if (row_q == ROW_A) begin
                    state_d = EVAL;
                end else begin
                    state_d = DWELL;
                    row_d   = row_q >> 1;
                end
            end
            EVAL: begin
                state_d = DWELL;
                row_d   = ROW_D;
                hits_d  = 2'd0;
                code_d  = NO_KEY;
            end
            default: begin
                state_d = DWELL;
                cnt_d   = CNT_RELOAD;
                row_d   = ROW_D;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DWELL;
            cnt_q   <= CNT_RELOAD;
            row_q   <= ROW_D;
            hits_q  <= 2'd0;
            code_q  <= NO_KEY;
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            hits_q  <= hits_d;
            code_q  <= code_d;
            sync1_q <= col_in;
            sync2_q <= sync1_q;
        end
    end

    assign row_out = row_q;

    keypad_debounce #(
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS),
        .REPEAT_SCANS   (REPEAT_SCANS)
    ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .eval      (state_q == EVAL),
        .scan_code ((hits_q == 2'd1) ? code_q : NO_KEY),
        .scan_amb  (hits_q == 2'd2),
        .key       (key),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
// ============================================================================
// Module  : tb_keypad_scanner
// Brief   : Directed self-checking bench for keypad_scanner (SCAN_DIV=4,
//           DEBOUNCE_SCANS=2, REPEAT_SCANS=3); honours KEYPAD_AUTOREPEAT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_keypad_scanner;

    localparam int         SCAN_LEN = 21;  // 4*(4+1)+1
    localparam logic [6:0] KEY_C = 7'b0100010;
    localparam logic [6:0] KEY_A = 7'b0001100;
    localparam logic [6:0] KEY_G = 7'b0010001;
    localparam logic [6:0] KEY_B = 7'b1000001;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam bit AUTOREPEAT = 1'b1;
`else
    localparam bit AUTOREPEAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] press_row = 4'b0000;
    logic [2:0] press_col = 3'b000;
    logic [2:0] col_in;
    logic [3:0] row_out;
    logic [6:0] key;
    logic       key_valid;
    logic       key_held;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    always #5 clk = ~clk;

    // A pressed key connects its row strobe to its column line.
    assign col_in = (row_out == press_row) ? press_col : 3'b000;

    keypad_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (2),
        .REPEAT_SCANS   (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .col_in    (col_in),
        .row_out   (row_out),
        .key       (key),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] row_at(input int p);
        if (p < 5)       return 4'b1000;
        else if (p < 10) return 4'b0100;
        else if (p < 15) return 4'b0010;
        else             return 4'b0001;
    endfunction

    task automatic run_scans(input int n, input bit check_rows);
        pulses = 0;
        for (int s = 0; s < n; s++) begin
            for (int i = 1; i <= SCAN_LEN; i++) begin
                tick();
                if (key_valid === 1'b1) pulses++;
                if (check_rows) check("row_seq", {28'd0, row_out}, {28'd0, row_at(i % SCAN_LEN)});
            end
        end
    endtask

    task automatic press(input logic [3:0] r, input logic [2:0] c);
        press_row = r;
        press_col = c;
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        check("rst_row", row_out, 4'b1000);
        check("rst_key", key, 7'd0);
        check("rst_valid", key_valid, 1'b0);
        check("rst_held", key_held, 1'b0);
        rst = 1'b0;

        run_scans(1, 1'b1);
        check("idle_pulses", pulses, 0);
        check("idle_key", key, 7'd0);
        run_scans(1, 1'b0);
        check("idle_pulses2", pulses, 0);

        // Single key f on row c
        press(4'b0100, 3'b010);
        run_scans(1, 1'b0);
        check("c_scan1_pulses", pulses, 0);
        check("c_scan1_key", key, 7'd0);
        run_scans(1, 1'b0);
        check("c_scan2_pulses", pulses, 1);
        check("c_scan2_key", key, KEY_C);
        check("c_scan2_held", key_held, 1'b1);
        run_scans(1, 1'b0);
        check("c_scan3_pulses", pulses, 0);
        check("c_scan3_key", key, KEY_C);

        // Release
        press(4'b0000, 3'b000);
        run_scans(1, 1'b0);
        check("rel1_key", key, KEY_C);
        check("rel1_held", key_held, 1'b1);
        run_scans(1, 1'b0);
        check("rel2_key", key, 7'd0);
        check("rel2_held", key_held, 1'b0);
        check("rel2_pulses", pulses, 0);

        // One-scan glitch on row b col g
        press(4'b0010, 3'b001);
        run_scans(1, 1'b0);
        check("glitch_pulses", pulses, 0);
        press(4'b0000, 3'b000);
        run_scans(2, 1'b0);
        check("glitch_after_pulses", pulses, 0);
        check("glitch_key", key, 7'd0);

        // Ambiguous scan must not disturb the release debounce in progress
        press(4'b0001, 3'b100);
        run_scans(2, 1'b0);
        check("a_commit_pulses", pulses, 1);
        check("a_commit_key", key, KEY_A);
        press(4'b0000, 3'b000);
        run_scans(1, 1'b0);
        press(4'b1000, 3'b101);
        run_scans(1, 1'b0);
        check("amb_pulses", pulses, 0);
        check("amb_key", key, KEY_A);
        check("amb_held", key_held, 1'b1);
        press(4'b0000, 3'b000);
        run_scans(1, 1'b0);
        check("amb_rel_key", key, 7'd0);
        check("amb_rel_held", key_held, 1'b0);
        check("amb_rel_pulses", pulses, 0);

        // Reset in the middle of row b while a key is held
        press(4'b0100, 3'b010);
        run_scans(2, 1'b0);
        check("pre_rst_key", key, KEY_C);
        check("pre_rst_pulses", pulses, 1);
        repeat (12) tick();
        check("mid_row_b", row_out, 4'b0010);
        rst = 1'b1;
        tick();
        tick();
        check("mid_rst_row", row_out, 4'b1000);
        check("mid_rst_key", key, 7'd0);
        check("mid_rst_valid", key_valid, 1'b0);
        check("mid_rst_held", key_held, 1'b0);
        rst = 1'b0;
        run_scans(1, 1'b1);
        check("post_rst1_pulses", pulses, 0);
        check("post_rst1_key", key, 7'd0);
        run_scans(1, 1'b0);
        check("post_rst2_pulses", pulses, 1);
        check("post_rst2_key", key, KEY_C);
        check("post_rst2_held", key_held, 1'b1);

        // Direct change C -> B without release
        press(4'b1000, 3'b001);
        run_scans(1, 1'b0);
        check("chg1_pulses", pulses, 0);
        check("chg1_key", key, KEY_C);
        run_scans(1, 1'b0);
        check("chg2_pulses", pulses, 1);
        check("chg2_key", key, KEY_B);

        // Long hold: one pulse, plus repeats when auto-repeat is built in
        press(4'b0000, 3'b000);
        run_scans(2, 1'b0);
        check("long_pre_key", key, 7'd0);
        press(4'b0001, 3'b100);
        for (int s = 1; s <= 10; s++) begin
            run_scans(1, 1'b0);
            check($sformatf("hold_scan%0d_pulses", s), pulses,
                  ((s == 2) || (AUTOREPEAT && (s == 5 || s == 8))) ? 1 : 0);
        end
        check("hold_key", key, KEY_A);
        check("hold_held", key_held, 1'b1);
        check("unused_glitch_code", {25'd0, KEY_G} ^ {25'd0, key}, {25'd0, KEY_G ^ KEY_A});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
